nzcv_flag_unit: RTL and testbench
=================================

// Module: nzcv_flag_unit
// PURPOSE
//   Producer side of the condition-flag interface: computes N/Z/C/V from ALU operations, holds the
//   architectural flags register, and drives flags[3:0] = {Z,C,N,V}, the exact ordering the branch
//   condition checker consumes. Includes a small flag save/restore stack for exception entry/return.
// PARAMETERS
//   WIDTH        32  datapath width of operands/result
//   STACK_DEPTH  4   number of saved flag nibbles (>=1)
// PORTS
//   clk           in   1      rising-edge clock
//   rst           in   1      synchronous, active-high reset
//   upd_valid     in   1      operation present this cycle
//   set_flags     in   1      S-bit: operation writes flags (ignored when upd_valid=0)
//   op            in   2      00 AND, 01 ADD, 10 SUB, 11 EOR
//   use_carry     in   1      ADD->ADC, SUB->SBC using current C
//   op_a, op_b    in   WIDTH  operands
//   shifter_carry in   1      carry-out of operand-B shifter, used as C for logical ops
//   result        out  WIDTH  registered operation result
//   result_valid  out  1      result holds a new value this cycle
//   flags         out  4      {Z,C,N,V}, registered
//   push, pop     in   1      save current flags / restore top entry
//   stack_full    out  1      STACK_DEPTH entries held
//   stack_empty   out  1      no entries held
//   stack_err     out  1      sticky: overflow, underflow or push+pop collision
// BEHAVIOUR
//   - Reset: flags=4'b0000, result=0, result_valid=0, stack empty (full=0, empty=1), stack_err=0.
//     All inputs ignored while rst=1; reset mid-operation discards the in-flight op.
//   - Latency 1: op sampled at edge t; result/result_valid/flags valid after edge t. A conditional
//     branch in the following cycle sees updated flags. result_valid=upd_valid delayed by one cycle.
//   - ADD: {co,r} = a + b + (use_carry ? C : 0); C=co; V=(a[M]==b[M]) && (r[M]!=a[M]), M=WIDTH-1.
//   - SUB: {co,r} = a + ~b + (use_carry ? C : 1); C=co (ARM no-borrow); V=(a[M]!=b[M]) && (r[M]!=a[M]).
//   - AND/EOR: r=a&b / a^b; C=shifter_carry; V unchanged.
//   - All ops: Z=(r==0), N=r[M]. Flags written only if upd_valid && set_flags; result always written
//     when upd_valid.
//   - Flag write priority per edge: rst > pop (restore) > arithmetic update > hold.
//   - push: stores flags value present before the edge; same-edge arithmetic update still applies.
//   - pop: flags <= top entry; same-edge set_flags update is discarded (result still produced).
//   - push when full: dropped, stack unchanged, stack_err<=1. pop when empty: flags hold, err<=1.
//   - push && pop same cycle: stack and flags unchanged by either, stack_err<=1.
//   - Stack is LIFO; pointer never wraps; stack_err cleared only by rst.
// TESTING
//   1. rst; ADD 0x7FFFFFFF+0x1, set_flags=1 -> result 0x80000000, flags 4'b0011, result_valid 1 cycle.
//   2. SUB 5-5, set_flags=1 -> result 0, flags 4'b1100 (Z=1,C=1).
//   3. set_flags=0, ADD 0xFFFFFFFF+0x1 -> result 0, flags unchanged from previous value.
//   4. flags 4'b0001 (V=1); AND 0xF0&0x0F, shifter_carry=1 -> result 0, flags 4'b1101 (V kept).
//   5. flags 4'b1100; push; SUB 1-2 -> flags 4'b0010; pop -> flags 4'b1100, stack_empty=1;
//      push STACK_DEPTH+1 times -> stack_full=1, stack_err=1; pop on empty also sets err.
//   6. C=1; ADD use_carry 0xFFFFFFFF+0x0 -> result 0, flags 4'b1100; assert rst with upd_valid=1 -> all
//      outputs at reset values next cycle.

Source files
------------

// File: rtl/nzcv_flag_unit_if.sv
// Condition-flag producer bus: ALU operation in, registered result and {Z,C,N,V} flags out,
// plus the flag save/restore stack controls and status.
interface nzcv_flag_unit_if #(
    parameter int WIDTH = 32
);
    logic             upd_valid;
    logic             set_flags;
    logic [1:0]       op;
    logic             use_carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             shifter_carry;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic [3:0]       flags;
    logic             push;
    logic             pop;
    logic             stack_full;
    logic             stack_empty;
    logic             stack_err;

    modport master (
        output upd_valid, set_flags, op, use_carry, op_a, op_b, shifter_carry, push, pop,
        input  result, result_valid, flags, stack_full, stack_empty, stack_err
    );

    modport slave (
        input  upd_valid, set_flags, op, use_carry, op_a, op_b, shifter_carry, push, pop,
        output result, result_valid, flags, stack_full, stack_empty, stack_err
    );
endinterface

// File: rtl/nzcv_flag_unit.sv
// Computes N/Z/C/V from ALU operations, holds the architectural flags as {Z,C,N,V}
// and keeps a small LIFO of saved flag nibbles for exception entry/return.
module nzcv_flag_unit #(
    parameter int WIDTH       = 32,
    parameter int STACK_DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    nzcv_flag_unit_if.slave bus
);
    localparam int M  = WIDTH - 1;
    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

    logic [3:0]       flags_q;
    logic [WIDTH-1:0] result_q;
    logic             result_valid_q;
    logic             stack_err_q;
    logic [CW-1:0]    depth;
    logic [3:0]       stack_mem [STACK_DEPTH];

    logic             c_cur;
    logic             v_cur;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic             alu_v;
    logic [3:0]       new_flags;
    logic             full;
    logic             empty;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    push_idx;

    assign c_cur    = flags_q[2];
    assign v_cur    = flags_q[0];
    assign full     = (depth == CW'(STACK_DEPTH));
    assign empty    = (depth == '0);
    assign top_idx  = AW'(depth - 1'b1);
    assign push_idx = AW'(depth);

    // SUB is a + ~b + 1, so C is the ARM-style "no borrow" carry out.
    always_comb begin
        cin   = 1'b0;
        sum   = '0;
        alu_r = '0;
        alu_c = c_cur;
        alu_v = v_cur;
        case (bus.op)
            OP_AND: begin
                alu_r = bus.op_a & bus.op_b;
                alu_c = bus.shifter_carry;
            end
            OP_ADD: begin
                cin   = bus.use_carry ? c_cur : 1'b0;
                sum   = {1'b0, bus.op_a} + {1'b0, bus.op_b} + {{WIDTH{1'b0}}, cin};
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (bus.op_a[M] == bus.op_b[M]) && (alu_r[M] != bus.op_a[M]);
            end
            OP_SUB: begin
                cin   = bus.use_carry ? c_cur : 1'b1;
                sum   = {1'b0, bus.op_a} + {1'b0, ~bus.op_b} + {{WIDTH{1'b0}}, cin};
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (bus.op_a[M] != bus.op_b[M]) && (alu_r[M] != bus.op_a[M]);
            end
            default: begin
                alu_r = bus.op_a ^ bus.op_b;
                alu_c = bus.shifter_carry;
            end
        endcase
        new_flags = {(alu_r == '0), alu_c, alu_r[M], alu_v};
    end

    // A lone pop (even on an empty stack) owns the flags this edge and masks the ALU update.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q        <= 4'b0000;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            depth          <= '0;
            stack_err_q    <= 1'b0;
        end else begin
            result_valid_q <= bus.upd_valid;
            if (bus.upd_valid) begin
                result_q <= alu_r;
            end

            if (bus.push && bus.pop) begin
                stack_err_q <= 1'b1;
            end else if (bus.pop) begin
                if (empty) begin
                    stack_err_q <= 1'b1;
                end else begin
                    flags_q <= stack_mem[top_idx];
                    depth   <= depth - 1'b1;
                end
            end else if (bus.push) begin
                if (full) begin
                    stack_err_q <= 1'b1;
                end else begin
                    stack_mem[push_idx] <= flags_q;
                    depth               <= depth + 1'b1;
                end
            end

            if (bus.upd_valid && bus.set_flags && !(bus.pop && !bus.push)) begin
                flags_q <= new_flags;
            end
        end
    end

    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.flags        = flags_q;
    assign bus.stack_full   = full;
    assign bus.stack_empty  = empty;
    assign bus.stack_err    = stack_err_q;
endmodule

// File: tb/tb_nzcv_flag_unit.sv
// Directed bench for nzcv_flag_unit: hand-computed results and {Z,C,N,V} flags for ALU ops,
// flag stack LIFO/overflow/underflow/collision behaviour and synchronous reset.
module tb_nzcv_flag_unit;
    localparam logic [1:0] AND_OP = 2'b00;
    localparam logic [1:0] ADD_OP = 2'b01;
    localparam logic [1:0] SUB_OP = 2'b10;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    nzcv_flag_unit_if #(.WIDTH(32)) bus ();

    nzcv_flag_unit #(.WIDTH(32), .STACK_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic rst_i, input logic upd, input logic sf,
                                  input logic [1:0] op, input logic uc,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic sc, input logic psh, input logic pp);
        @(negedge clk);
        rst               = rst_i;
        bus.upd_valid     = upd;
        bus.set_flags     = sf;
        bus.op            = op;
        bus.use_carry     = uc;
        bus.op_a          = a;
        bus.op_b          = b;
        bus.shifter_carry = sc;
        bus.push          = psh;
        bus.pop           = pp;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, 1'b0, AND_OP, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        bus.upd_valid = 1'b0; bus.set_flags = 1'b0; bus.op = 2'b00; bus.use_carry = 1'b0;
        bus.op_a = '0; bus.op_b = '0; bus.shifter_carry = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;

        // Reset state
        apply_stimulus(1'b1, 1'b0, 1'b0, AND_OP, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_output("rst_flags", bus.flags, 4'b0000);
        check_output("rst_result", bus.result, 32'h0);
        check_output("rst_rvalid", bus.result_valid, 1'b0);
        check_output("rst_empty", bus.stack_empty, 1'b1);
        check_output("rst_full", bus.stack_full, 1'b0);
        check_output("rst_err", bus.stack_err, 1'b0);

        // 1: signed overflow on ADD
        apply_stimulus(1'b0, 1'b1, 1'b1, ADD_OP, 1'b0, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        check_output("add_ovf_result", bus.result, 32'h80000000);
        check_output("add_ovf_flags", bus.flags, 4'b0011);
        check_output("add_ovf_rvalid", bus.result_valid, 1'b1);
        idle();
        check_output("rvalid_drop", bus.result_valid, 1'b0);
        check_output("result_hold", bus.result, 32'h80000000);

        // 2: SUB equal operands
        apply_stimulus(1'b0, 1'b1, 1'b1, SUB_OP, 1'b0, 32'h5, 32'h5, 1'b0, 1'b0, 1'b0);
        check_output("sub_eq_result", bus.result, 32'h0);
        check_output("sub_eq_flags", bus.flags, 4'b1100);

        // 3: no S-bit
        apply_stimulus(1'b0, 1'b1, 1'b0, ADD_OP, 1'b0, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        check_output("nos_result", bus.result, 32'h0);
        check_output("nos_flags", bus.flags, 4'b1100);

        // 4: V preserved across logical ops
        apply_stimulus(1'b0, 1'b1, 1'b1, ADD_OP, 1'b0, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1, AND_OP, 1'b0, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0);
        check_output("and_vonly_flags", bus.flags, 4'b0001);
        apply_stimulus(1'b0, 1'b1, 1'b1, AND_OP, 1'b0, 32'hF0, 32'h0F, 1'b1, 1'b0, 1'b0);
        check_output("and_zero_result", bus.result, 32'h0);
        check_output("and_zero_flags", bus.flags, 4'b1101);
        apply_stimulus(1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 32'hFFFF0000, 32'h0000FFFF, 1'b0, 1'b0, 1'b0);
        check_output("eor_result", bus.result, 32'hFFFFFFFF);
        check_output("eor_flags", bus.flags, 4'b0011);

        // 5: stack LIFO, push with same-edge update, pop masking update
        apply_stimulus(1'b0, 1'b1, 1'b1, SUB_OP, 1'b0, 32'h5, 32'h5, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1, SUB_OP, 1'b0, 32'h1, 32'h2, 1'b0, 1'b1, 1'b0);
        check_output("push_sub_result", bus.result, 32'hFFFFFFFF);
        check_output("push_sub_flags", bus.flags, 4'b0010);
        check_output("push_not_empty", bus.stack_empty, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, AND_OP, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1, SUB_OP, 1'b0, 32'h5, 32'h5, 1'b0, 1'b0, 1'b0);
        check_output("pre_pop_flags", bus.flags, 4'b1100);
        apply_stimulus(1'b0, 1'b1, 1'b1, ADD_OP, 1'b0, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 1'b1);
        check_output("pop1_flags", bus.flags, 4'b0010);
        check_output("pop1_result", bus.result, 32'h80000000);
        check_output("pop1_not_empty", bus.stack_empty, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, AND_OP, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        check_output("pop2_flags", bus.flags, 4'b1100);
        check_output("pop2_empty", bus.stack_empty, 1'b1);
        check_output("pop2_err", bus.stack_err, 1'b0);

        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, AND_OP, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        end
        check_output("fill_full", bus.stack_full, 1'b1);
        check_output("fill_err", bus.stack_err, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, AND_OP, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        check_output("ovf_full", bus.stack_full, 1'b1);
        check_output("ovf_err", bus.stack_err, 1'b1);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, AND_OP, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        end
        check_output("drain3_empty", bus.stack_empty, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, AND_OP, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        check_output("drain4_empty", bus.stack_empty, 1'b1);

        // Underflow after a fresh reset; pop also masks the same-edge update
        apply_stimulus(1'b1, 1'b0, 1'b0, AND_OP, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_output("rst2_err", bus.stack_err, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1, SUB_OP, 1'b0, 32'h5, 32'h5, 1'b0, 1'b0, 1'b1);
        check_output("unf_err", bus.stack_err, 1'b1);
        check_output("unf_flags", bus.flags, 4'b0000);
        check_output("unf_empty", bus.stack_empty, 1'b1);

        // Push+pop collision after reset
        apply_stimulus(1'b1, 1'b0, 1'b0, AND_OP, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, AND_OP, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        check_output("coll_err", bus.stack_err, 1'b1);
        check_output("coll_empty", bus.stack_empty, 1'b1);
        check_output("coll_flags", bus.flags, 4'b0000);

        // 6: carry-in variants, then reset with an op in flight
        apply_stimulus(1'b0, 1'b1, 1'b1, SUB_OP, 1'b1, 32'h5, 32'h5, 1'b0, 1'b0, 1'b0);
        check_output("sbc_c0_result", bus.result, 32'hFFFFFFFF);
        check_output("sbc_c0_flags", bus.flags, 4'b0010);
        apply_stimulus(1'b0, 1'b1, 1'b1, SUB_OP, 1'b0, 32'h5, 32'h5, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1, ADD_OP, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0);
        check_output("adc_result", bus.result, 32'h0);
        check_output("adc_flags", bus.flags, 4'b1100);
        apply_stimulus(1'b0, 1'b1, 1'b1, ADD_OP, 1'b1, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0);
        check_output("adc_c1_result", bus.result, 32'h3);
        check_output("adc_c1_flags", bus.flags, 4'b0000);
        apply_stimulus(1'b1, 1'b1, 1'b1, ADD_OP, 1'b0, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 1'b0);
        check_output("rst3_flags", bus.flags, 4'b0000);
        check_output("rst3_result", bus.result, 32'h0);
        check_output("rst3_rvalid", bus.result_valid, 1'b0);
        check_output("rst3_empty", bus.stack_empty, 1'b1);
        check_output("rst3_full", bus.stack_full, 1'b0);
        check_output("rst3_err", bus.stack_err, 1'b0);

        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
